// File: rtl/fir_sym_seq.sv
// rtl/fir_sym_seq.sv - time-multiplexed symmetric K-tap FIR sequencer (optional FIR_SYM_SEQ_COEF_SHADOW_EN)
// One pre-adder and one MAC are shared across the K/2 coefficient pairs.
module fir_sym_seq #(
    parameter int K      = 32,
    parameter int D_BITS = 16,
    parameter int M_BITS = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic signed [D_BITS-1:0]         x_i,
    input  logic                             x_valid_i,
    output logic                             x_ready_o,
    output logic signed [D_BITS+M_BITS-1:0]  y_o,
    output logic                             y_valid_o,
    input  logic                             y_ready_i,
    input  logic                             coef_we_i,
    input  logic [$clog2(K/2)-1:0]           coef_addr_i,
    input  logic signed [M_BITS-1:0]         coef_data_i,
`ifdef FIR_SYM_SEQ_COEF_SHADOW_EN
    input  logic                             coef_commit_i,
`endif
    output logic                             busy_o
);

    localparam int PTR_W  = $clog2(K);
    localparam int IDX_W  = $clog2(K/2);
    localparam int PRE_W  = D_BITS + 1;
    localparam int PROD_W = D_BITS + M_BITS + 1;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam int Y_W    = D_BITS + M_BITS;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [D_BITS-1:0]  dline [K];
    logic signed [M_BITS-1:0]  coef  [K/2];
    logic [PTR_W-1:0]          wp, base;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic signed [PRE_W-1:0]   pre;
    logic signed [PROD_W-1:0]  prod;
    logic signed [Y_W-1:0]     y_sat;
    logic [PTR_W-1:0]          tap_new, tap_old;
    logic                      accept, last;

    assign accept = x_valid_i && (state == IDLE);
    assign last   = (state == MAC) && (idx == IDX_W'(K/2-1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_ready_o = 1'b0;
        y_valid_o = 1'b0;
        busy_o    = 1'b0;
        case (state)
            IDLE: begin
                x_ready_o = 1'b1;
                if (accept) state_nxt = MAC;
            end
            MAC: begin
                busy_o = 1'b1;
                if (last) state_nxt = OUT;
            end
            OUT: begin
                busy_o    = 1'b1;
                y_valid_o = 1'b1;
                if (y_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // base is where the current sample landed; pair j is x[n-j] and x[n-K+1+j]
    always_comb begin
        tap_new = base - PTR_W'(idx);
        tap_old = base + PTR_W'(idx) + PTR_W'(1);
        pre     = PRE_W'(dline[tap_new]) + PRE_W'(dline[tap_old]);
        prod    = PROD_W'(pre) * PROD_W'(coef[idx]);
        acc_nxt = acc + ACC_W'(prod);
        if (acc_nxt > SAT_MAX)      y_sat = SAT_MAX[Y_W-1:0];
        else if (acc_nxt < SAT_MIN) y_sat = SAT_MIN[Y_W-1:0];
        else                        y_sat = acc_nxt[Y_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < K; i++) dline[i] <= '0;
            wp   <= '0;
            base <= '0;
            idx  <= '0;
            acc  <= '0;
            y_o  <= '0;
        end else begin
            if (accept) begin
                dline[wp] <= x_i;
                base      <= wp;
                wp        <= wp + PTR_W'(1);
                acc       <= '0;
                idx       <= '0;
            end else if (state == MAC) begin
                acc <= acc_nxt;
                idx <= idx + IDX_W'(1);
                if (last) y_o <= y_sat;
            end
        end
    end

`ifdef FIR_SYM_SEQ_COEF_SHADOW_EN
    logic signed [M_BITS-1:0] shadow [K/2];
    logic                     commit_pend;

    // a commit arriving on the copy edge stays pending for the next idle edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < K/2; i++) begin
                shadow[i] <= '0;
                coef[i]   <= '0;
            end
            commit_pend <= 1'b0;
        end else begin
            if (coef_we_i) shadow[coef_addr_i] <= coef_data_i;
            if ((state == IDLE) && commit_pend) begin
                for (int i = 0; i < K/2; i++) coef[i] <= shadow[i];
            end
            commit_pend <= coef_commit_i || (commit_pend && (state != IDLE));
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < K/2; i++) coef[i] <= '0;
        end else if (coef_we_i && (state == IDLE)) begin
            coef[coef_addr_i] <= coef_data_i;
        end
    end
`endif

endmodule

// File: doc/fir_sym_seq.md
Name: fir_sym_seq

Overview:
- Time-multiplexed sequencer for a symmetric K-tap FIR. One pre-adder and one multiplier-accumulator are shared across all K/2 coefficient pairs.
- Owns the sample delay line, the coefficient bank and the MAC schedule.
- Sits between the sample source and downstream consumers. Uses valid/ready on both sides, so the fast system clock can replace the fully parallel filter when the sample rate is low.

Parameters:
- K, 32, tap count; even power of two, minimum 4.
- D_BITS, 16, signed sample width.
- M_BITS, 16, signed coefficient width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- x_i  in  D_BITS  signed input sample.
- x_valid_i  in  1  sample valid.
- x_ready_o  out  1  sequencer can accept a sample.
- y_o  out  D_BITS+M_BITS  signed filter output.
- y_valid_o  out  1  output valid.
- y_ready_i  in  1  downstream accepts output.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  $clog2(K/2)  coefficient index j.
- coef_data_i  in  M_BITS  signed coefficient value.
- busy_o  out  1  high in MAC or OUT.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE.
  - Delay line, coefficients, write pointer wp, index idx and accumulator acc all cleared to 0.
  - y_o=0, y_valid_o=0, busy_o=0, x_ready_o=1 once reset is released.
  - Reset asserted mid-MAC or mid-OUT aborts the computation; no output is produced.
- Filter definition:
  - y[n] = sum over j=0..K/2-1 of c[j]*(x[n-j] + x[n-K+1+j]).
  - c[j] is written at coef_addr_i=j.
- Delay line:
  - K-entry circular buffer; the new sample is written at wp, then wp=wp+1 mod K.
  - Tap x[n-j] = buf[(wp_at_accept - j) mod K]; wrap-around is modular.
- Widths:
  - Pre-add: D_BITS+1.
  - Product: D_BITS+M_BITS+1.
  - acc: D_BITS+M_BITS+1+$clog2(K/2), signed.
  - y_o is acc saturated to the D_BITS+M_BITS signed range (max positive / min negative). No rounding, no shift.
- State machine:
  - IDLE: x_ready_o=1. On x_valid_i&x_ready_o at edge E: store sample, acc=0, idx=0, go to MAC.
  - MAC: exactly K/2 cycles, idx=0..K/2-1. Each edge performs acc+=c[idx]*(pair sum).
    - On the edge with idx=K/2-1, the final sum is saturated into y_o, y_valid_o is set, and the state goes to OUT.
    - y_valid_o therefore rises after edge E+K/2.
  - OUT: y_o and y_valid_o are held stable while y_ready_i=0.
    - The edge with y_ready_i=1 clears y_valid_o and returns to IDLE.
    - x_ready_o=0 in OUT, so there is no same-cycle accept.
    - Minimum sample period is K/2+2 cycles.
- x_ready_o=0 in MAC and OUT. x_valid_i held high by the source while ready is low is simply accepted later, with no loss.
- Coefficient writes:
  - Applied at the clock edge only while state is IDLE.
  - A write while busy_o=1 is ignored, so the computation in flight always uses one consistent coefficient set.
  - A write in IDLE together with a sample accept in the same edge takes effect for that sample's computation.

Optional Feature:
- Macro: FIR_SYM_SEQ_COEF_SHADOW_EN.
- When defined:
  - Adds port coef_commit_i (in, 1).
  - Writes go to a shadow bank and are accepted in any state.
  - coef_commit_i sets a commit-pending flag. Shadow is copied to active on the first edge at which the state is IDLE with the flag set; that edge also clears the flag.
  - The copy applies to a sample accepted on that same edge.
  - Reset clears both banks and the flag.
- When undefined:
  - No shadow bank and no commit port.
  - IDLE-only write rule above.

Test Plan:
- Impulse (K=32): write c[j]=j+1 for j=0..15; send x=1 followed by 31 zeros -> consecutive outputs 1,2,...,16,16,15,...,1, then 0.
- DC: all c[j]=1; feed x=1000 continuously -> first 31 outputs ramp up; the 32nd and all later outputs are 32000. y_valid_o rises 16 cycles after each accept.
- Saturation (D_BITS=M_BITS=16): all c[j]=-32768; feed x=-32768 continuously -> steady output 2147483647 (true value 2^35).
- Backpressure: hold y_ready_i=0 for 5 cycles while y_valid_o=1 -> y_o stable, x_ready_o=0, a pending x_valid_i is not accepted; release -> IDLE then accept on the next edge.
- Reset mid-MAC: assert rst_i at idx=7 -> y_valid_o=0 immediately; afterwards an impulse x=1 reproduces the impulse response with all-zero coefficients, i.e. y=0.
- Coefficient write while busy (macro off): write c[0]=100 during MAC -> ignored, so c[0] keeps its old value. With the macro on: write then commit during MAC -> the current output uses the old set and the next sample uses c[0]=100.
